ploc_occupancy_tracker: RTL and testbench

- Consumes the single-cycle o_car_enter / o_car_exit pulses from the parking-lot gate FSM.
- Maintains the current lot occupancy as a binary count and a parallel BCD count for the seven-segment display stage.
- Flags full/empty conditions and records illegal events (entry when full, exit when empty) in a small status FSM with sticky error flags.

---
 rtl/ploc_pkg.sv | 15 +
 rtl/bcd_updown_digit.sv | 36 +++
 rtl/ploc_occupancy_tracker.sv | 143 ++++++++++++++
 tb/tb_ploc_occupancy_tracker.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ploc_pkg.sv
// ploc_pkg: shared types and constants for the parking-lot occupancy tracker.
//   t_occ_state : status FSM encoding (EMPTY / AVAIL / FULL / FAULT).
//   BCD_MAX     : largest value a single BCD digit may hold.
package ploc_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_AVAIL = 2'd1,
      ST_FULL  = 2'd2,
      ST_FAULT = 2'd3
   } t_occ_state;

   localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_updown_digit.sv
// bcd_updown_digit: one BCD digit that counts up or down by one.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (digit resets to 0)
//   i_inc, i_dec   : step requests, never both high (inc wins if they are)
//   o_digit        : current digit value, 0..9
//   o_carry        : high when this step wraps 9 -> 0; drives the next digit's i_inc
//   o_borrow       : high when this step wraps 0 -> 9; drives the next digit's i_dec
// Carry and borrow are combinational so a whole digit chain steps in the same cycle.
module bcd_updown_digit
   import ploc_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_inc,
   input  logic       i_dec,
   output logic [3:0] o_digit,
   output logic       o_carry,
   output logic       o_borrow
);

   logic [3:0] digit_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         digit_q <= 4'd0;
      end else if (i_inc) begin
         digit_q <= (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
      end else if (i_dec) begin
         digit_q <= (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
      end
   end

   assign o_digit  = digit_q;
   assign o_carry  = i_inc && (digit_q == BCD_MAX);
   assign o_borrow = i_dec && !i_inc && (digit_q == 4'd0);

endmodule

// File: rtl/ploc_occupancy_tracker.sv
// ploc_occupancy_tracker: lot occupancy counter with BCD mirror and status FSM.
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_car_enter/exit   : one-cycle event pulses from the gate FSM
//   i_clr_err          : level; clears sticky flags and leaves FAULT
//   o_count, o_bcd     : occupancy in binary and in BCD (digit 0 in [3:0])
//   o_full, o_empty    : decode of o_count
//   o_err_over/under   : sticky illegal-event flags
//   o_fault            : status FSM is in ST_FAULT
//   o_state            : status FSM state, for observation
// Handshake: the event pulses carry no valid/ready pair; every pulse sampled on a
// rising edge is consumed on that edge and there is no backpressure.
module ploc_occupancy_tracker
   import ploc_pkg::*;
#(
   parameter  int CAPACITY   = 99,
   parameter  int BCD_DIGITS = 3,
   localparam int COUNT_W    = $clog2(CAPACITY + 1)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_car_enter,
   input  logic                    i_car_exit,
   input  logic                    i_clr_err,
   output logic [COUNT_W-1:0]      o_count,
   output logic [4*BCD_DIGITS-1:0] o_bcd,
   output logic                    o_full,
   output logic                    o_empty,
   output logic                    o_err_over,
   output logic                    o_err_under,
   output logic                    o_fault,
   output t_occ_state              o_state
);

   localparam logic [COUNT_W-1:0] CAP_VAL = COUNT_W'(CAPACITY);

   logic [COUNT_W-1:0] count_q, count_d;
   logic               over_q, over_d;
   logic               under_q, under_d;
   t_occ_state         state_q, state_d;

   logic is_full, is_empty;
   logic do_inc, do_dec, ill_over, ill_under;

   assign is_full  = (count_q == CAP_VAL);
   assign is_empty = (count_q == '0);

   // Simultaneous enter and exit is a net-zero event and is never an error.
   assign do_inc    = i_car_enter && !i_car_exit && !is_full;
   assign do_dec    = i_car_exit && !i_car_enter && !is_empty;
   assign ill_over  = i_car_enter && !i_car_exit && is_full;
   assign ill_under = i_car_exit && !i_car_enter && is_empty;

   always_comb begin
      count_d = count_q;
      over_d  = over_q;
      under_d = under_q;
      state_d = state_q;

      if (do_inc) begin
         count_d = count_q + 1'b1;
      end else if (do_dec) begin
         count_d = count_q - 1'b1;
      end

      if (ill_over || ill_under) begin
         state_d = ST_FAULT;
         // A clear arriving with a new error drops the old flags but keeps the new one.
         if (state_q == ST_FAULT && i_clr_err) begin
            over_d  = ill_over;
            under_d = ill_under;
         end else begin
            over_d  = over_q || ill_over;
            under_d = under_q || ill_under;
         end
      end else if (state_q == ST_FAULT && !i_clr_err) begin
         state_d = ST_FAULT;
      end else begin
         if (state_q == ST_FAULT) begin
            over_d  = 1'b0;
            under_d = 1'b0;
         end
         if (count_d == '0) begin
            state_d = ST_EMPTY;
         end else if (count_d == CAP_VAL) begin
            state_d = ST_FULL;
         end else begin
            state_d = ST_AVAIL;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_q <= '0;
         over_q  <= 1'b0;
         under_q <= 1'b0;
         state_q <= ST_EMPTY;
      end else begin
         count_q <= count_d;
         over_q  <= over_d;
         under_q <= under_d;
         state_q <= state_d;
      end
   end

   // BCD mirror: steps on exactly the same legal events as the binary count.
   logic [BCD_DIGITS-1:0] carry;
   logic [BCD_DIGITS-1:0] borrow;

   for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
      logic inc_in, dec_in;
      if (i == 0) begin : g_lsd
         assign inc_in = do_inc;
         assign dec_in = do_dec;
      end else begin : g_upper
         assign inc_in = carry[i-1];
         assign dec_in = borrow[i-1];
      end
      bcd_updown_digit u_digit (
         .i_clk    (i_clk),
         .i_rst_n  (i_rst_n),
         .i_inc    (inc_in),
         .i_dec    (dec_in),
         .o_digit  (o_bcd[4*i +: 4]),
         .o_carry  (carry[i]),
         .o_borrow (borrow[i])
      );
   end

   // The most significant carry/borrow cannot fire because the count stays
   // within 0..CAPACITY, which always fits in BCD_DIGITS digits.
   logic msd_wrap_unused;
   assign msd_wrap_unused = carry[BCD_DIGITS-1] | borrow[BCD_DIGITS-1];

   assign o_count     = count_q;
   assign o_full      = is_full;
   assign o_empty     = is_empty;
   assign o_err_over  = over_q;
   assign o_err_under = under_q;
   assign o_fault     = (state_q == ST_FAULT);
   assign o_state     = state_q;

endmodule

// File: tb/tb_ploc_occupancy_tracker.sv
// tb_ploc_occupancy_tracker: directed bench with a reference model feeding an
// expected queue; a monitor on the falling edge pops and compares.
module tb_ploc_occupancy_tracker;
   import ploc_pkg::*;

   localparam int CAP = 99;

   // ---------------- clock / reset ----------------
   logic i_clk = 1'b0;
   logic i_rst_n;
   logic i_car_enter, i_car_exit, i_clr_err;
   logic [6:0]  o_count;
   logic [11:0] o_bcd;
   logic        o_full, o_empty, o_err_over, o_err_under, o_fault;
   t_occ_state  o_state;

   always #5 i_clk = ~i_clk;

   ploc_occupancy_tracker #(.CAPACITY(CAP), .BCD_DIGITS(3)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_car_enter (i_car_enter),
      .i_car_exit  (i_car_exit),
      .i_clr_err   (i_clr_err),
      .o_count     (o_count),
      .o_bcd       (o_bcd),
      .o_full      (o_full),
      .o_empty     (o_empty),
      .o_err_over  (o_err_over),
      .o_err_under (o_err_under),
      .o_fault     (o_fault),
      .o_state     (o_state)
   );

   // ---------------- reference model ----------------
   int         m_count;
   logic       m_over, m_under;
   t_occ_state m_state;

   function automatic logic [11:0] to_bcd(input int v);
      logic [3:0] d2, d1, d0;
      d2 = 4'(v / 100);
      d1 = 4'((v / 10) % 10);
      d0 = 4'(v % 10);
      return {d2, d1, d0};
   endfunction

   function automatic logic [25:0] model_vec();
      logic [6:0] c;
      logic [1:0] s;
      c = 7'(m_count);
      s = m_state;
      return {c, to_bcd(m_count), (m_count == CAP), (m_count == 0),
              m_over, m_under, (m_state == ST_FAULT), s};
   endfunction

   task automatic model_reset();
      m_count = 0;
      m_over  = 1'b0;
      m_under = 1'b0;
      m_state = ST_EMPTY;
   endtask

   task automatic model_step(input logic e, input logic x, input logic c);
      bit bad_o, bad_u;
      bad_o = e && !x && (m_count == CAP);
      bad_u = x && !e && (m_count == 0);
      if (e && !x && !bad_o) m_count++;
      if (x && !e && !bad_u) m_count--;
      if (bad_o || bad_u) begin
         if (m_state == ST_FAULT && c) begin
            m_over  = bad_o;
            m_under = bad_u;
         end else begin
            m_over  = m_over | bad_o;
            m_under = m_under | bad_u;
         end
         m_state = ST_FAULT;
      end else if (m_state == ST_FAULT && !c) begin
         m_state = ST_FAULT;
      end else begin
         if (m_state == ST_FAULT) begin
            m_over  = 1'b0;
            m_under = 1'b0;
         end
         if (m_count == 0)        m_state = ST_EMPTY;
         else if (m_count == CAP) m_state = ST_FULL;
         else                     m_state = ST_AVAIL;
      end
   endtask

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [25:0] exp_q[$];

   function automatic logic [25:0] actual_vec();
      logic [1:0] s;
      s = o_state;
      return {o_count, o_bcd, o_full, o_empty, o_err_over, o_err_under, o_fault, s};
   endfunction

   task automatic compare(input string tag, input logic [25:0] got, input logic [25:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got count=%0d bcd=%h full=%b empty=%b over=%b under=%b fault=%b st=%0d | want count=%0d bcd=%h full=%b empty=%b over=%b under=%b fault=%b st=%0d",
                  tag, got[25:19], got[18:7], got[6], got[5], got[4], got[3], got[2], got[1:0],
                  want[25:19], want[18:7], want[6], want[5], want[4], want[3], want[2], want[1:0]);
      end
   endtask

   int step_no = 0;

   always @(negedge i_clk) begin
      if (exp_q.size() > 0) begin
         logic [25:0] e;
         e = exp_q.pop_front();
         compare($sformatf("step%0d", step_no), actual_vec(), e);
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic e, input logic x, input logic c);
      i_car_enter = e;
      i_car_exit  = x;
      i_clr_err   = c;
      @(posedge i_clk);
      model_step(e, x, c);
      step_no++;
      exp_q.push_back(model_vec());
      @(negedge i_clk);
      i_car_enter = 1'b0;
      i_car_exit  = 1'b0;
      i_clr_err   = 1'b0;
   endtask

   task automatic repeat_drive(input int n, input logic e, input logic x);
      for (int i = 0; i < n; i++) drive(e, x, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      i_rst_n     = 1'b0;
      i_car_enter = 1'b0;
      i_car_exit  = 1'b0;
      i_clr_err   = 1'b0;
      model_reset();
      @(negedge i_clk);
      @(negedge i_clk);
      compare("reset_state", actual_vec(), model_vec());
      i_rst_n = 1'b1;

      // Fill: 12 cars, then to capacity, then one overflow attempt.
      repeat_drive(12, 1'b1, 1'b0);
      repeat_drive(CAP - 12, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0);          // overflow -> FAULT, over set
      drive(1'b1, 1'b1, 1'b0);          // net zero while full and faulted
      drive(1'b0, 1'b0, 1'b1);          // clear -> FULL
      drive(1'b1, 1'b1, 1'b0);          // net zero at FULL, no error
      drive(1'b0, 1'b0, 1'b1);          // clear outside FAULT: no effect

      // Drain to 10, exercise borrow and carry, then drain to 0.
      repeat_drive(CAP - 10, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b0);          // 10 -> 9
      drive(1'b1, 1'b0, 1'b0);          // 9 -> 10
      repeat_drive(10, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0);          // net zero at EMPTY, no error
      drive(1'b0, 1'b0, 1'b1);          // clear outside FAULT

      // Underflow, legal traffic while faulted, second flag, clear racing an error.
      drive(1'b0, 1'b1, 1'b0);          // underflow -> FAULT, under set
      repeat_drive(CAP, 1'b1, 1'b0);    // count still moves in FAULT
      drive(1'b1, 1'b0, 1'b0);          // overflow too -> both flags
      drive(1'b1, 1'b0, 1'b1);          // clear + new overflow: only over remains
      drive(1'b0, 1'b0, 1'b1);          // clear -> FULL

      // Down to 40, then asynchronous reset between edges.
      repeat_drive(CAP - 40, 1'b0, 1'b1);
      #2;
      i_rst_n = 1'b0;
      #1;
      model_reset();
      compare("async_reset", actual_vec(), model_vec());
      @(negedge i_clk);
      compare("reset_held", actual_vec(), model_vec());
      i_rst_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0);          // 0 -> 1 after release

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge i_clk);
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expected entries never compared, want 0", exp_q.size());
      end
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
